// File: rtl/wb_single_master_if.sv
// rtl/wb_single_master_if.sv - local request/response port and Wishbone pipelined bus bundle
interface wb_single_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_i;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_adr_i;
  logic [3:0]            req_sel_i;
  logic [31:0]           req_dat_i;
  logic                  req_ready_o;
  logic                  rsp_valid_o;
  logic [31:0]           rsp_dat_o;
  logic [1:0]            rsp_status_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;
  logic [31:0]           wb_dat_i;

  modport master (
    input  req_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

  modport slave (
    output req_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );
endinterface

// File: rtl/wb_single_master.sv
// rtl/wb_single_master.sv - single-command Wishbone pipelined initiator with bounded retry and timeout
module wb_single_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  wb_single_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_STB, S_WAIT, S_BACKOFF} state_t;

  state_t state;
  state_t state_d;

  logic                  cyc_q;
  logic                  stb_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [3:0]            sel_q;
  logic [31:0]           dat_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_dat_q;
  logic [1:0]            rsp_status_q;
  logic [RW-1:0]         retry_q;
  logic [TW-1:0]         tmo_q;

  logic       accept;
  logic       term;
  logic       timed_out;
  logic       finish;
  logic       retry_inc;
  logic       load_rdata;
  logic [1:0] status_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    finish     = 1'b0;
    retry_inc  = 1'b0;
    load_rdata = 1'b0;
    status_d   = 2'b00;
    term       = bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i;
    timed_out  = (tmo_q == TW'(TIMEOUT - 1));
    case (state)
      S_IDLE: begin
        if (bus.req_i) begin
          accept  = 1'b1;
          state_d = S_STB;
        end
      end
      S_STB, S_WAIT: begin
        // A termination outranks both stall and the timeout in the same cycle.
        if (term) begin
          if (bus.wb_err_i) begin
            finish   = 1'b1;
            status_d = 2'b01;
          end else if (bus.wb_rty_i) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_inc = 1'b1;
              state_d   = S_BACKOFF;
            end else begin
              finish   = 1'b1;
              status_d = 2'b10;
            end
          end else begin
            finish     = 1'b1;
            load_rdata = ~we_q;
          end
        end else if (timed_out) begin
          finish   = 1'b1;
          status_d = 2'b11;
        end else if (state == S_STB && !bus.wb_stall_i) begin
          state_d = S_WAIT;
        end
      end
      S_BACKOFF: state_d = S_STB;
      default:   state_d = S_IDLE;
    endcase
    if (finish) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= 2'b00;
      retry_q      <= '0;
      tmo_q        <= '0;
    end else begin
      // Bus strobes follow the next state so they stay registered outputs.
      cyc_q       <= (state_d == S_STB) || (state_d == S_WAIT);
      stb_q       <= (state_d == S_STB);
      rsp_valid_q <= finish;
      if (finish)     rsp_status_q <= status_d;
      if (load_rdata) rsp_dat_q    <= bus.wb_dat_i;
      if (accept) begin
        we_q    <= bus.req_we_i;
        adr_q   <= bus.req_adr_i;
        sel_q   <= bus.req_sel_i;
        dat_q   <= bus.req_dat_i;
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
      if (state_d == S_STB && state != S_STB) tmo_q <= '0;
      else if (state == S_STB || state == S_WAIT) tmo_q <= tmo_q + 1'b1;
    end
  end

  assign bus.req_ready_o  = (state == S_IDLE);
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;
  assign bus.wb_cyc_o     = cyc_q;
  assign bus.wb_stb_o     = stb_q;
  assign bus.wb_we_o      = we_q;
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_sel_o     = sel_q;
  assign bus.wb_dat_o     = dat_q;
endmodule

// File: tb/tb_wb_single_master.sv
// tb/tb_wb_single_master.sv - directed self-checking bench for wb_single_master
module tb_wb_single_master;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  wb_single_master_if #(.ADDR_WIDTH(32)) bus ();

  wb_single_master #(
    .ADDR_WIDTH(32),
    .TIMEOUT   (8),
    .MAX_RETRY (3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bus.req_i     = 1'b1;
    bus.req_we_i  = we;
    bus.req_adr_i = adr;
    bus.req_sel_i = 4'hF;
    bus.req_dat_i = dat;
    step();
    bus.req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_i = 1'b0; bus.req_we_i = 1'b0; bus.req_adr_i = '0;
    bus.req_sel_i = '0; bus.req_dat_i = '0;
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
    bus.wb_stall_i = 1'b0; bus.wb_dat_i = '0;
    step(); step();

    chk("rst_ready", bus.req_ready_o, 1);
    chk("rst_cyc", bus.wb_cyc_o, 0);
    chk("rst_stb", bus.wb_stb_o, 0);
    chk("rst_valid", bus.rsp_valid_o, 0);
    chk("rst_dat", bus.rsp_dat_o, 0);
    chk("rst_status", bus.rsp_status_o, 0);
    rst = 1'b0;
    step();

    // write, no stall
    issue(1'b1, 32'h10, 32'hCAFEF00D);
    chk("wr_c1_cyc", bus.wb_cyc_o, 1);
    chk("wr_c1_stb", bus.wb_stb_o, 1);
    chk("wr_c1_we", bus.wb_we_o, 1);
    chk("wr_c1_adr", bus.wb_adr_o, 32'h10);
    chk("wr_c1_sel", bus.wb_sel_o, 4'hF);
    chk("wr_c1_dat", bus.wb_dat_o, 32'hCAFEF00D);
    chk("wr_c1_ready", bus.req_ready_o, 0);
    step();
    chk("wr_c2_cyc", bus.wb_cyc_o, 1);
    chk("wr_c2_stb", bus.wb_stb_o, 0);
    chk("wr_c2_dat", bus.wb_dat_o, 32'hCAFEF00D);
    bus.wb_ack_i = 1'b1;
    step();
    bus.wb_ack_i = 1'b0;
    chk("wr_c3_valid", bus.rsp_valid_o, 1);
    chk("wr_c3_status", bus.rsp_status_o, 2'b00);
    chk("wr_c3_cyc", bus.wb_cyc_o, 0);
    chk("wr_c3_ready", bus.req_ready_o, 1);
    step();
    chk("wr_c4_valid", bus.rsp_valid_o, 0);

    // read against stall-until-ack slave
    bus.wb_stall_i = 1'b1;
    issue(1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_stb", bus.wb_stb_o, 1);
      chk("stall_valid", bus.rsp_valid_o, 0);
      step();
    end
    chk("stall_c4_stb", bus.wb_stb_o, 1);
    chk("stall_c4_we", bus.wb_we_o, 0);
    bus.wb_stall_i = 1'b0;
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h12345678;
    step();
    bus.wb_ack_i = 1'b0;
    chk("stall_rsp_valid", bus.rsp_valid_o, 1);
    chk("stall_rsp_status", bus.rsp_status_o, 2'b00);
    chk("stall_rsp_dat", bus.rsp_dat_o, 32'h12345678);
    chk("stall_rsp_cyc", bus.wb_cyc_o, 0);
    step();

    // rty twice then ack
    issue(1'b0, 32'h30, 32'h0);
    for (int k = 0; k < 2; k++) begin
      chk("rty_stb", bus.wb_stb_o, 1);
      step();
      chk("rty_wait_stb", bus.wb_stb_o, 0);
      bus.wb_rty_i = 1'b1;
      step();
      bus.wb_rty_i = 1'b0;
      chk("rty_gap_cyc", bus.wb_cyc_o, 0);
      chk("rty_gap_valid", bus.rsp_valid_o, 0);
      chk("rty_gap_adr", bus.wb_adr_o, 32'h30);
      step();
    end
    chk("rty_3rd_stb", bus.wb_stb_o, 1);
    step();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hA5A5A5A5;
    step();
    bus.wb_ack_i = 1'b0;
    chk("rty_rsp_valid", bus.rsp_valid_o, 1);
    chk("rty_rsp_status", bus.rsp_status_o, 2'b00);
    chk("rty_rsp_dat", bus.rsp_dat_o, 32'hA5A5A5A5);
    step();

    // retry exhaustion: four rty, terminated straight from STB
    issue(1'b0, 32'h34, 32'h0);
    bus.wb_dat_i = 32'h55555555;
    for (int k = 0; k < 4; k++) begin
      chk("exh_stb", bus.wb_stb_o, 1);
      bus.wb_rty_i = 1'b1;
      step();
      bus.wb_rty_i = 1'b0;
      if (k < 3) begin
        chk("exh_gap_cyc", bus.wb_cyc_o, 0);
        chk("exh_gap_valid", bus.rsp_valid_o, 0);
        step();
      end
    end
    chk("exh_valid", bus.rsp_valid_o, 1);
    chk("exh_status", bus.rsp_status_o, 2'b10);
    chk("exh_dat_kept", bus.rsp_dat_o, 32'hA5A5A5A5);
    chk("exh_cyc", bus.wb_cyc_o, 0);
    step();

    // err and ack together: err wins, read data not captured
    issue(1'b0, 32'h38, 32'h0);
    bus.wb_ack_i = 1'b1;
    bus.wb_err_i = 1'b1;
    bus.wb_dat_i = 32'hDEADBEEF;
    step();
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    chk("err_valid", bus.rsp_valid_o, 1);
    chk("err_status", bus.rsp_status_o, 2'b01);
    chk("err_dat_kept", bus.rsp_dat_o, 32'hA5A5A5A5);
    step();

    // timeout with silent slave
    issue(1'b0, 32'h3C, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      chk("tmo_cyc_high", bus.wb_cyc_o, 1);
      chk("tmo_no_valid", bus.rsp_valid_o, 0);
      step();
    end
    chk("tmo_cyc_low", bus.wb_cyc_o, 0);
    chk("tmo_valid", bus.rsp_valid_o, 1);
    chk("tmo_status", bus.rsp_status_o, 2'b11);
    chk("tmo_ready", bus.req_ready_o, 1);
    bus.wb_ack_i = 1'b1;
    step();
    bus.wb_ack_i = 1'b0;
    chk("late_ack_valid", bus.rsp_valid_o, 0);
    chk("late_ack_cyc", bus.wb_cyc_o, 0);
    step();
    chk("late_ack_valid2", bus.rsp_valid_o, 0);

    // ack on the last allowed cycle beats the timeout
    issue(1'b0, 32'h44, 32'h0);
    for (int i = 1; i < 8; i++) step();
    chk("tmo_edge_cyc", bus.wb_cyc_o, 1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h0BADF00D;
    step();
    bus.wb_ack_i = 1'b0;
    chk("tmo_edge_valid", bus.rsp_valid_o, 1);
    chk("tmo_edge_status", bus.rsp_status_o, 2'b00);
    chk("tmo_edge_dat", bus.rsp_dat_o, 32'h0BADF00D);
    step();

    // asynchronous reset while in WAIT
    issue(1'b1, 32'h48, 32'h99990000);
    step();
    chk("arst_wait_cyc", bus.wb_cyc_o, 1);
    chk("arst_wait_stb", bus.wb_stb_o, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cyc", bus.wb_cyc_o, 0);
    chk("arst_stb", bus.wb_stb_o, 0);
    chk("arst_valid", bus.rsp_valid_o, 0);
    bus.wb_ack_i = 1'b1;
    step();
    bus.wb_ack_i = 1'b0;
    chk("arst_hold_valid", bus.rsp_valid_o, 0);
    chk("arst_hold_cyc", bus.wb_cyc_o, 0);
    rst = 1'b0;
    step();
    chk("arst_after_valid", bus.rsp_valid_o, 0);
    chk("arst_after_ready", bus.req_ready_o, 1);

    issue(1'b1, 32'h50, 32'h11112222);
    chk("post_stb", bus.wb_stb_o, 1);
    chk("post_adr", bus.wb_adr_o, 32'h50);
    chk("post_dat", bus.wb_dat_o, 32'h11112222);
    step();
    bus.wb_ack_i = 1'b1;
    step();
    bus.wb_ack_i = 1'b0;
    chk("post_valid", bus.rsp_valid_o, 1);
    chk("post_status", bus.rsp_status_o, 2'b00);
    step();
    chk("post_idle_cyc", bus.wb_cyc_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_single_master.md
# wb_single_master

Wishbone pipelined-mode bus initiator that turns single read/write commands from a local request port into one Wishbone classic-pipelined transaction each, and returns data and status on a response port. It sits between a local controller (sequencer, debug bridge, test driver) and the generated register-bank slaves. It handles stall, ack, err and rty, with bounded retry and a per-attempt timeout.

## Interface
- `ADDR_WIDTH`, default 32: width of `req_adr_i` and `wb_adr_o`.
- `TIMEOUT`, default 255: maximum cycles with `wb_cyc_o` high per attempt before abort; must be ≥ 2.
- `MAX_RETRY`, default 3: number of re-issues allowed after `wb_rty_i`.

Ports:
- `clk_i`  in  1  single clock; all logic rising-edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_i`  in  1  command valid; sampled only when `req_ready_o`=1.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_adr_i`  in  ADDR_WIDTH  byte address.
- `req_sel_i`  in  4  byte selects.
- `req_dat_i`  in  32  write data.
- `req_ready_o`  out  1  command accepted when `req_i`=1 in this cycle.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_dat_o`  out  32  read data; held until next response.
- `rsp_status_o`  out  2  00 ok, 01 bus error, 10 retries exhausted, 11 timeout.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone master controls.
- `wb_adr_o`  out  ADDR_WIDTH  address.
- `wb_sel_o`  out  4  byte selects.
- `wb_dat_o`  out  32  write data.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`, `wb_stall_i`  in  1  slave responses.
- `wb_dat_i`  in  32  slave read data.

## Operation
- States: IDLE, STB, WAIT, BACKOFF.
- Reset values: state IDLE, all registered outputs 0, counters 0. `req_ready_o`=1 while in IDLE, but no command is accepted while `rst_i`=1.
- IDLE:
  - `req_ready_o`=1. On `req_i`=1, latch we/adr/sel/dat into the `wb_*` output registers, clear the retry counter, and go to STB.
- STB: `wb_cyc_o`=`wb_stb_o`=1.
  - If a termination (ack/err/rty) is sampled, terminate, even when `wb_stall_i`=0 in the same cycle. Slaves that hold stall until ack rely on this.
  - Otherwise, if `wb_stall_i`=0, go to WAIT.
  - Otherwise stay in STB.
- WAIT: `wb_cyc_o`=1, `wb_stb_o`=0. Stay until a termination is sampled.
- Termination priority when several are asserted together: err > rty > ack.
  - ack: for a read, `rsp_dat_o`←`wb_dat_i`; status 00.
  - err: status 01; `rsp_dat_o` unchanged.
  - rty with retry count < MAX_RETRY: increment the count and go to BACKOFF. No response is issued.
  - rty with retry count = MAX_RETRY: status 10.
- BACKOFF: one cycle with `wb_cyc_o`=0, then STB with the same latched command.
- Any final termination sets `wb_cyc_o`=`wb_stb_o`=0 and `rsp_valid_o`=1 in the next cycle, and the state returns to IDLE.
- Timeout counter:
  - Cleared on every entry to STB; increments each cycle in STB or WAIT.
  - A cycle with count = TIMEOUT−1 and no termination aborts: the cycle is dropped, status is 11, and no retry is attempted.
  - A termination in that same cycle wins over the timeout.
- `wb_ack_i`/`wb_err_i`/`wb_rty_i` in IDLE or BACKOFF (late or stray responses) are ignored.
- Asynchronous reset mid-transaction: `wb_cyc_o`/`wb_stb_o` drop immediately and no response is emitted.

## Timing
- Command accepted at edge 0. `wb_cyc_o`/`wb_stb_o` are high from cycle 1.
- Best case: no stall and ack in cycle 2. `rsp_valid_o` is high in cycle 3, and `req_ready_o` is high in cycle 3, so a back-to-back command can be accepted in the same cycle as the response pulse.
- Slave with stall held until ack in cycle N: a single STB phase, and the response arrives in cycle N+1.
- Each retry adds 1 cycle of BACKOFF plus the new attempt.
- All Wishbone outputs and `rsp_*` are registered, with no combinational input-to-output path. `req_ready_o` is decoded from state only.

## Test plan
- Write with no stall: `req_i` with we=1, adr=0x10, sel=0xF, dat=0xCAFEF00D. Required: cyc/stb high exactly 1 cycle with stb, ack in cycle 2, `rsp_valid_o` in cycle 3 with status 00, and `wb_dat_o`=0xCAFEF00D during the cycle.
- Read against a stall-until-ack slave: stall for 3 cycles, then ack with `wb_dat_i`=0x12345678 and stall=0 in the same cycle. Required: a single transfer, response status 00 and `rsp_dat_o`=0x12345678.
- Retry: slave answers rty twice, then ack. Required: two 1-cycle cyc-low gaps, three stb phases, one response with status 00. Retry exhaustion: MAX_RETRY=3 with 4 rtys gives status 10.
- Error precedence: ack and err asserted together gives status 01, and `rsp_dat_o` keeps its previous value.
- Timeout: TIMEOUT=8 with a slave that never responds. Required: cyc high exactly 8 cycles, then status 11, then IDLE. A late ack after the abort produces no second response.
- Reset mid-transaction: assert `rst_i` while in WAIT. Required: cyc/stb 0 immediately, no `rsp_valid_o`, and a fresh command after reset completes normally.
